framebuffer_scanout: RTL

//  Reader end of the background framebuffer: the paint blocks write 2-bit palette indices into RAM;

---
 rtl/fb_pkg.sv | 39 +++
 rtl/video_timing_gen.sv | 62 ++++++
 rtl/framebuffer_scanout.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer types: palette index, RGB pixel, palette lookup table
// and the per-pixel record carried through the scanout delay pipe.
package fb_pkg;

    typedef logic [1:0] palette_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam palette_t PALETTE_WHITE = 2'd3;
    localparam rgb_t     RGB_BLACK     = rgb_t'(24'h000000);

    localparam rgb_t PALETTE_RGB [4] = '{
        rgb_t'(24'h000000),
        rgb_t'(24'h535353),
        rgb_t'(24'hACACAC),
        rgb_t'(24'hFFFFFF)
    };

    // Timing flags plus the colour source for one pixel. in_fb selects the RAM
    // data; otherwise pal is a fixed index decided at counter time.
    typedef struct packed {
        logic     de;
        logic     hsync;
        logic     vsync;
        logic     in_fb;
        palette_t pal;
    } pipe_t;

    localparam pipe_t PIPE_RESET = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1, in_fb: 1'b0, pal: 2'd0};

    function automatic rgb_t palette_to_rgb(input palette_t idx);
        return PALETTE_RGB[idx];
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Panel timing generator: free-running h/v counters, active region,
// active-low syncs and a start-of-vblank pulse, all in counter time.
module video_timing_gen #(
    parameter int unsigned COOR_WIDTH = 12,
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned H_FP       = 210,
    parameter int unsigned H_SYNC     = 20,
    parameter int unsigned H_BP       = 26,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 22,
    parameter int unsigned V_SYNC     = 10,
    parameter int unsigned V_BP       = 13
) (
    input  logic                  clk_33m,
    input  logic                  rst_n,
    output logic [COOR_WIDTH-1:0] h,
    output logic [COOR_WIDTH-1:0] v,
    output logic                  active,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COOR_WIDTH-1:0] H_LAST   = COOR_WIDTH'(H_TOTAL - 1);
    localparam logic [COOR_WIDTH-1:0] V_LAST   = COOR_WIDTH'(V_TOTAL - 1);
    localparam logic [COOR_WIDTH-1:0] H_ACT    = COOR_WIDTH'(H_ACTIVE);
    localparam logic [COOR_WIDTH-1:0] V_ACT    = COOR_WIDTH'(V_ACTIVE);
    localparam logic [COOR_WIDTH-1:0] HS_START = COOR_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [COOR_WIDTH-1:0] HS_END   = COOR_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COOR_WIDTH-1:0] VS_START = COOR_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [COOR_WIDTH-1:0] VS_END   = COOR_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

    logic [COOR_WIDTH-1:0] h_q;
    logic [COOR_WIDTH-1:0] v_q;

    // Pixel counter wraps at end of line; line counter advances on that wrap.
    always_ff @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_q <= h_q + 1'b1;
        end
    end

    // Region and sync decode straight from the counters.
    always_comb begin
        h           = h_q;
        v           = v_q;
        active      = (h_q < H_ACT) && (v_q < V_ACT);
        hsync       = !((h_q >= HS_START) && (h_q < HS_END));
        vsync       = !((v_q >= VS_START) && (v_q < VS_END));
        frame_start = (h_q == '0) && (v_q == V_ACT);
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer scanout: panel timing, scrolled RAM read addressing, timing
// delay pipe aligned to RAM latency, and palette-to-RGB output register.
// Build option SCANOUT_TEST_PATTERN_EN: RAM reads disabled, active area shows
// four vertical bars of palette index h[9:8]; output latency is unchanged.
module framebuffer_scanout
    import fb_pkg::*;
#(
    parameter int unsigned COOR_WIDTH   = 12,
    parameter int unsigned FB_WIDTH     = 1280,
    parameter int unsigned FB_HEIGHT    = 300,
    parameter int unsigned FB_Y_OFFSET  = 90,
    parameter int unsigned H_ACTIVE     = 800,
    parameter int unsigned H_FP         = 210,
    parameter int unsigned H_SYNC       = 20,
    parameter int unsigned H_BP         = 26,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 22,
    parameter int unsigned V_SYNC       = 10,
    parameter int unsigned V_BP         = 13,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clk_33m,
    input  logic                  rst_n,
    input  logic [COOR_WIDTH-1:0] scroll_x,
    output logic                  read_en,
    output logic [COOR_WIDTH-1:0] read_x,
    output logic [COOR_WIDTH-1:0] read_y,
    input  palette_t              read_palette,
    output logic [7:0]            video_red,
    output logic [7:0]            video_green,
    output logic [7:0]            video_blue,
    output logic                  video_hsync,
    output logic                  video_vsync,
    output logic                  video_de,
    output logic                  frame_start
);

    localparam logic [COOR_WIDTH:0]   FB_W    = (COOR_WIDTH + 1)'(FB_WIDTH);
    localparam logic [COOR_WIDTH-1:0] Y_FIRST = COOR_WIDTH'(FB_Y_OFFSET);
    localparam logic [COOR_WIDTH-1:0] Y_END   = COOR_WIDTH'(FB_Y_OFFSET + FB_HEIGHT);

    logic [COOR_WIDTH-1:0] h;
    logic [COOR_WIDTH-1:0] v;
    logic                  active;
    logic                  hsync;
    logic                  vsync;

    video_timing_gen #(
        .COOR_WIDTH (COOR_WIDTH),
        .H_ACTIVE   (H_ACTIVE),
        .H_FP       (H_FP),
        .H_SYNC     (H_SYNC),
        .H_BP       (H_BP),
        .V_ACTIVE   (V_ACTIVE),
        .V_FP       (V_FP),
        .V_SYNC     (V_SYNC),
        .V_BP       (V_BP)
    ) u_timing (
        .clk_33m     (clk_33m),
        .rst_n       (rst_n),
        .h           (h),
        .v           (v),
        .active      (active),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    logic [COOR_WIDTH-1:0] scroll_q;

    // Scroll is taken once per frame so a frame never tears; out-of-range means no scroll.
    always_ff @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            scroll_q <= '0;
        end else if ((h == '0) && (v == '0)) begin
            scroll_q <= ({1'b0, scroll_x} >= FB_W) ? '0 : scroll_x;
        end
    end

    logic              in_band;
    logic [COOR_WIDTH:0] x_sum;
    pipe_t             stage_d;

    // Read address and the counter-time pipe record.
    always_comb begin
        in_band = (v >= Y_FIRST) && (v < Y_END);
        // One extra bit so h + scroll never overflows before the wrap test.
        x_sum   = {1'b0, h} + {1'b0, scroll_q};
        if (x_sum >= FB_W) begin
            x_sum = x_sum - FB_W;
        end
        read_en = 1'b0;
        read_x  = '0;
        read_y  = '0;
        stage_d = '{de: active, hsync: hsync, vsync: vsync, in_fb: 1'b0, pal: PALETTE_WHITE};
`ifdef SCANOUT_TEST_PATTERN_EN
        stage_d.pal = h[9:8];
`else
        if (active && in_band) begin
            read_en       = 1'b1;
            read_x        = x_sum[COOR_WIDTH-1:0];
            read_y        = v - Y_FIRST;
            stage_d.in_fb = 1'b1;
        end
`endif
    end

    pipe_t [READ_LATENCY:0] pipe_q;

    // Delay timing flags so they line up with RAM data and the RGB register.
    always_ff @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= READ_LATENCY; i++) begin
                pipe_q[i] <= PIPE_RESET;
            end
        end else begin
            pipe_q[0] <= stage_d;
            for (int unsigned i = 1; i <= READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    pipe_t rd_stage;
    rgb_t  rgb_d;
    rgb_t  rgb_q;

    // Colour select in the cycle the RAM data arrives; blanking forces black.
    always_comb begin
        rd_stage = pipe_q[READ_LATENCY-1];
        rgb_d    = RGB_BLACK;
        if (rd_stage.de) begin
            rgb_d = palette_to_rgb(rd_stage.in_fb ? read_palette : rd_stage.pal);
        end
    end

    // RGB output register, one stage after the RAM data.
    always_ff @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= RGB_BLACK;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    // Output pins come from the last pipe stage and the RGB register.
    always_comb begin
        video_red   = rgb_q.r;
        video_green = rgb_q.g;
        video_blue  = rgb_q.b;
        video_de    = pipe_q[READ_LATENCY].de;
        video_hsync = pipe_q[READ_LATENCY].hsync;
        video_vsync = pipe_q[READ_LATENCY].vsync;
    end

endmodule
